// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a request/ready instruction memory
// port and feeds (PC+4, instruction, flush) to the IF/ID register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Hazard,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCOut,
    output logic [31:0] InstOut,
    output logic        IF_IDFlash
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pc, pc_nxt;
    logic [XLEN-1:0]   inst_buf, inst_buf_nxt;
    logic [XLEN-1:0]   pend_pc, pend_pc_nxt;
    logic [XLEN-1:0]   redirect_al;
    logic [XLEN-1:0]   pc_inc;

    // Low address bits are dropped by masking so every input bit is consumed.
    assign redirect_al = RedirectPC & ~XLEN'(3);
    assign pc_inc      = pc + XLEN'(4);

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            inst_buf <= '0;
            pend_pc  <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            inst_buf <= inst_buf_nxt;
            pend_pc  <= pend_pc_nxt;
        end
    end

    // Next-state and output decode; outputs are forced to idle while in reset.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        inst_buf_nxt = inst_buf;
        pend_pc_nxt  = pend_pc;
        imem_req     = 1'b0;
        imem_addr    = '0;
        IF_IDFlash   = 1'b1;
        InstOut      = '0;
        PCOut        = pc_inc;

        case (state)
            FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc;
                if (imem_ready) begin
                    if (Redirect) begin
                        pc_nxt = redirect_al;
                    end else begin
                        IF_IDFlash = 1'b0;
                        InstOut    = imem_rdata;
                        if (Hazard) begin
                            inst_buf_nxt = imem_rdata;
                            state_nxt    = HOLD;
                        end else begin
                            pc_nxt = pc_inc;
                        end
                    end
                end else if (Redirect) begin
                    // Outstanding transfer must complete before the target is requested.
                    pend_pc_nxt = redirect_al;
                    state_nxt   = DRAIN;
                end
            end
            HOLD: begin
                if (Redirect) begin
                    pc_nxt    = redirect_al;
                    state_nxt = FETCH;
                end else begin
                    IF_IDFlash = 1'b0;
                    InstOut    = inst_buf;
                    if (!Hazard) begin
                        pc_nxt    = pc_inc;
                        state_nxt = FETCH;
                    end
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = pc;
                if (Redirect) begin
                    pend_pc_nxt = redirect_al;
                end
                if (imem_ready) begin
                    pc_nxt    = Redirect ? redirect_al : pend_pc;
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase

        if (!rst_n) begin
            imem_req   = 1'b0;
            imem_addr  = '0;
            IF_IDFlash = 1'b1;
            InstOut    = '0;
            PCOut      = '0;
        end
    end

endmodule
